// File: rtl/bram_udp_pkg.sv
// Shared types and helpers for the bram2udp transmit path: FSM states, error bit
// indices, the last-beat byte mask and the UDP reply tuser layout.
package bram_udp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_RES   = 1;
  localparam int unsigned ERR_START = 2;
  localparam int unsigned ERR_W     = 3;

  localparam int unsigned TUSER_W = 64;

  // Low `rem` lanes set; rem == 0 means the last beat is full. Lanes at or above kw stay 0.
  function automatic logic [7:0] keep_mask(input logic [2:0] rem, input int unsigned kw);
    logic [7:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i] = (i < kw) && ((rem == 3'd0) || (i < 32'(rem)));
    end
    return m;
  endfunction

  // Reply header: ports swapped relative to the received frame.
  function automatic logic [TUSER_W-1:0] tx_tuser(input logic [15:0] len,
                                                  input logic [15:0] rx_src,
                                                  input logic [15:0] rx_dst);
    return {len, 16'd0, rx_dst, rx_src};
  endfunction

endpackage

// File: rtl/bram_tx_fifo.sv
// Synchronous first-word-fall-through FIFO: data_o is the head word whenever not empty.
// A flush empties it on the next edge and takes priority over push/pop.
module bram_tx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AW:0]       level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW + 1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/bram_tx_stream.sv
// CPU-to-AXI-Stream transmit framer: CPU fills the FIFO, then a validated start emits one
// frame with byte-accurate tkeep/tlast and a port-swapped UDP reply tuser.
module bram_tx_stream
  import bram_udp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned LEN_W  = 16,
  localparam int unsigned KW    = DATA_W / 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic [TUSER_W-1:0]   axi_rx_tuser_i,
  input  logic                 wr_valid_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 int_enable_i,
  input  logic                 int_tx_clear_i,
  input  logic                 err_clear_i,
  output logic                 INT_tx_o,
  output logic [ERR_W-1:0]     tx_error_o,
  output logic                 tx_busy_o,
  output logic [LVL_W-1:0]     fifo_level_o,
  input  logic                 axi_tx_tready_i,
  output logic                 axi_tx_tvalid_o,
  output logic [DATA_W-1:0]    axi_tx_tdata_o,
  output logic [KW-1:0]        axi_tx_tkeep_o,
  output logic                 axi_tx_tlast_o,
  output logic [TUSER_W-1:0]   axi_tx_tuser_o
);

  localparam int unsigned KB = $clog2(KW);

  logic              fifo_empty, fifo_full, fifo_flush;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;

  tx_state_e          state_q;
  logic [LEN_W-1:0]   beat_cnt_q;
  logic [KB-1:0]      rem_q;
  logic [TUSER_W-1:0] tuser_q;
  logic               int_q;
  logic [ERR_W-1:0]   err_q, err_set;

  logic [LEN_W:0] beats;
  logic           start_ok, tvalid, handshake, last_beat, last_hs, residue;
  logic [7:0]     last_mask;
  logic           unused_bits;

  // One extra bit so ceil(len/KW) cannot wrap for len near 2**LEN_W.
  assign beats    = ({1'b0, len_i} + (LEN_W + 1)'(KW - 1)) >> KB;
  assign start_ok = (len_i != '0) && (beats <= (LEN_W + 1)'(DEPTH));

  assign tvalid     = (state_q == SEND) && !fifo_empty;
  assign handshake  = tvalid && axi_tx_tready_i;
  assign last_beat  = (beat_cnt_q == LEN_W'(1));
  assign last_hs    = handshake && last_beat;
  assign fifo_flush = int_tx_clear_i && int_q && (state_q == IDLE);
  // Words left behind after the final pop, counting a push landing in the same cycle.
  assign residue    = (fifo_level != LVL_W'(1)) || (wr_valid_i && !fifo_full);

  always_comb begin
    err_set            = '0;
    err_set[ERR_OVF]   = wr_valid_i && fifo_full;
    err_set[ERR_RES]   = last_hs && residue;
    err_set[ERR_START] = start_i && ((state_q == SEND) || !start_ok);
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rem_q      <= '0;
      tuser_q    <= '0;
      int_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && start_ok) begin
            state_q    <= SEND;
            beat_cnt_q <= beats[LEN_W-1:0];
            rem_q      <= len_i[KB-1:0];
            tuser_q    <= tx_tuser(len_i[15:0], axi_rx_tuser_i[31:16], axi_rx_tuser_i[15:0]);
          end
        end
        SEND: begin
          if (handshake) beat_cnt_q <= beat_cnt_q - LEN_W'(1);
          if (last_hs)   state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (last_hs && int_enable_i) int_q <= 1'b1;
      else if (int_tx_clear_i)     int_q <= 1'b0;

      err_q <= err_set | (err_clear_i ? '0 : err_q);
    end
  end

  bram_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (sclk),
    .rst_i   (reset),
    .flush_i (fifo_flush),
    .push_i  (wr_valid_i),
    .data_i  (wr_data_i),
    .pop_i   (handshake),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign last_mask   = keep_mask(3'(rem_q), KW);
  assign unused_bits = ^{axi_rx_tuser_i[63:32], last_mask};

  assign axi_tx_tvalid_o = tvalid;
  assign axi_tx_tdata_o  = tvalid ? fifo_head : '0;
  assign axi_tx_tkeep_o  = !tvalid ? '0 : (last_beat ? last_mask[KW-1:0] : '1);
  assign axi_tx_tlast_o  = tvalid && last_beat;
  assign axi_tx_tuser_o  = tuser_q;
  assign INT_tx_o        = int_q;
  assign tx_error_o      = err_q;
  assign tx_busy_o       = (state_q == SEND);
  assign fifo_level_o    = fifo_level;

endmodule

// File: tb/tb_bram_tx_stream.sv
// Directed bench for bram_tx_stream: a 32-bit/16-deep instance for most cases and a
// 64-bit/16-deep instance for the wide-word back-pressure case.
module tb_bram_tx_stream;

  logic sclk = 1'b0;
  logic reset = 1'b1;
  always #5 sclk = ~sclk;

  // 32-bit instance
  logic [63:0] a_rx_tuser = '0;
  logic        a_wr_valid = 1'b0;
  logic [31:0] a_wr_data = '0;
  logic        a_start = 1'b0;
  logic [15:0] a_len = '0;
  logic        a_int_en = 1'b0, a_int_clr = 1'b0, a_err_clr = 1'b0, a_tready = 1'b0;
  logic        a_int, a_busy, a_tvalid, a_tlast;
  logic [2:0]  a_err;
  logic [4:0]  a_level;
  logic [31:0] a_tdata;
  logic [3:0]  a_tkeep;
  logic [63:0] a_tuser;

  // 64-bit instance
  logic [63:0] b_rx_tuser = '0;
  logic        b_wr_valid = 1'b0;
  logic [63:0] b_wr_data = '0;
  logic        b_start = 1'b0;
  logic [15:0] b_len = '0;
  logic        b_int_en = 1'b0, b_int_clr = 1'b0, b_err_clr = 1'b0, b_tready = 1'b0;
  logic        b_int, b_busy, b_tvalid, b_tlast;
  logic [2:0]  b_err;
  logic [4:0]  b_level;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [63:0] b_tuser;

  bram_tx_stream #(.DATA_W(32), .DEPTH(16), .LEN_W(16)) u_dut32 (
    .sclk            (sclk),
    .reset           (reset),
    .axi_rx_tuser_i  (a_rx_tuser),
    .wr_valid_i      (a_wr_valid),
    .wr_data_i       (a_wr_data),
    .start_i         (a_start),
    .len_i           (a_len),
    .int_enable_i    (a_int_en),
    .int_tx_clear_i  (a_int_clr),
    .err_clear_i     (a_err_clr),
    .INT_tx_o        (a_int),
    .tx_error_o      (a_err),
    .tx_busy_o       (a_busy),
    .fifo_level_o    (a_level),
    .axi_tx_tready_i (a_tready),
    .axi_tx_tvalid_o (a_tvalid),
    .axi_tx_tdata_o  (a_tdata),
    .axi_tx_tkeep_o  (a_tkeep),
    .axi_tx_tlast_o  (a_tlast),
    .axi_tx_tuser_o  (a_tuser)
  );

  bram_tx_stream #(.DATA_W(64), .DEPTH(16), .LEN_W(16)) u_dut64 (
    .sclk            (sclk),
    .reset           (reset),
    .axi_rx_tuser_i  (b_rx_tuser),
    .wr_valid_i      (b_wr_valid),
    .wr_data_i       (b_wr_data),
    .start_i         (b_start),
    .len_i           (b_len),
    .int_enable_i    (b_int_en),
    .int_tx_clear_i  (b_int_clr),
    .err_clear_i     (b_err_clr),
    .INT_tx_o        (b_int),
    .tx_error_o      (b_err),
    .tx_busy_o       (b_busy),
    .fifo_level_o    (b_level),
    .axi_tx_tready_i (b_tready),
    .axi_tx_tvalid_o (b_tvalid),
    .axi_tx_tdata_o  (b_tdata),
    .axi_tx_tkeep_o  (b_tkeep),
    .axi_tx_tlast_o  (b_tlast),
    .axi_tx_tuser_o  (b_tuser)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [2:0]  err;
  } start_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    a_wr_valid = 1'b1;
    a_wr_data  = d;
    @(negedge sclk);
    a_wr_valid = 1'b0;
  endtask

  task automatic push_b(input logic [63:0] d);
    b_wr_valid = 1'b1;
    b_wr_data  = d;
    @(negedge sclk);
    b_wr_valid = 1'b0;
  endtask

  task automatic pulse_a_int_clr();
    a_int_clr = 1'b1;
    @(negedge sclk);
    a_int_clr = 1'b0;
  endtask

  task automatic pulse_a_err_clr();
    a_err_clr = 1'b1;
    @(negedge sclk);
    a_err_clr = 1'b0;
  endtask

  beat_t      t1 [3];
  beat_t      t2 [2];
  beat_t      t6 [2];
  start_vec_t sv [3];
  int         idx;

  initial begin
    t1[0] = '{64'h44332211, 8'hF, 1'b0};
    t1[1] = '{64'h88776655, 8'hF, 1'b0};
    t1[2] = '{64'hCCBBAA99, 8'h3, 1'b1};
    t2[0] = '{64'h0807060504030201, 8'hFF, 1'b0};
    t2[1] = '{64'h100F0E0D0C0B0A09, 8'hFF, 1'b1};
    t6[0] = '{64'h11223344, 8'hF, 1'b0};
    t6[1] = '{64'h00000055, 8'h1, 1'b1};
    sv[0] = '{16'd0, 3'b100};
    sv[1] = '{16'd65, 3'b100};
    sv[2] = '{16'hFFFF, 3'b100};

    // Reset state
    repeat (2) @(negedge sclk);
    check("rst_tvalid", a_tvalid, 0);
    check("rst_tkeep", a_tkeep, 0);
    check("rst_tuser", a_tuser, 0);
    check("rst_level", a_level, 0);
    check("rst_err", a_err, 0);
    check("rst_busy", a_busy, 0);
    check("rst_int", a_int, 0);
    reset = 1'b0;
    @(negedge sclk);

    // 1: three words, len=10 -> keep F,F,3
    push_a(32'h44332211);
    push_a(32'h88776655);
    push_a(32'hCCBBAA99);
    check("t1_level", a_level, 3);
    a_int_en   = 1'b1;
    a_rx_tuser = 64'h0000_0000_1234_5678;
    a_start = 1'b1; a_len = 16'd10; a_tready = 1'b1;
    @(negedge sclk);
    a_start = 1'b0;
    check("t1_busy", a_busy, 1);
    check("t1_tuser", a_tuser, {16'd10, 16'd0, 16'h5678, 16'h1234});
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_tvalid%0d", i), a_tvalid, 1);
      check($sformatf("t1_tdata%0d", i), a_tdata, t1[i].data);
      check($sformatf("t1_tkeep%0d", i), a_tkeep, t1[i].keep);
      check($sformatf("t1_tlast%0d", i), a_tlast, t1[i].last);
      @(negedge sclk);
    end
    check("t1_done_tvalid", a_tvalid, 0);
    check("t1_done_busy", a_busy, 0);
    check("t1_int", a_int, 1);
    check("t1_err", a_err, 0);
    pulse_a_int_clr();
    check("t1_int_clr", a_int, 0);

    // 3: rejected starts
    for (int i = 0; i < 3; i++) begin
      a_start = 1'b1; a_len = sv[i].len;
      @(negedge sclk);
      a_start = 1'b0;
      check($sformatf("t3_err%0d", i), a_err, sv[i].err);
      check($sformatf("t3_busy%0d", i), a_busy, 0);
      check($sformatf("t3_tvalid%0d", i), a_tvalid, 0);
      pulse_a_err_clr();
      check($sformatf("t3_errclr%0d", i), a_err, 0);
    end

    // 4: overflow, full drain, then residue
    for (int i = 0; i < 16; i++) push_a(32'h100 + 32'(i));
    check("t4_full_level", a_level, 16);
    check("t4_full_err", a_err, 0);
    push_a(32'hDEAD);
    check("t4_ovf_err", a_err, 3'b001);
    check("t4_ovf_level", a_level, 16);
    pulse_a_err_clr();
    a_start = 1'b1; a_len = 16'd64;
    @(negedge sclk);
    a_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_tdata%0d", i), a_tdata, 32'h100 + 32'(i));
      check($sformatf("t4_tlast%0d", i), a_tlast, (i == 15) ? 1 : 0);
      @(negedge sclk);
    end
    check("t4_drain_err", a_err, 0);
    check("t4_drain_int", a_int, 1);
    pulse_a_int_clr();
    for (int i = 0; i < 4; i++) push_a(32'hA0 + 32'(i));
    a_start = 1'b1; a_len = 16'd8;
    @(negedge sclk);
    a_start = 1'b0;
    repeat (2) @(negedge sclk);
    check("t4_res_err", a_err, 3'b010);
    check("t4_res_level", a_level, 2);
    check("t4_res_int", a_int, 1);
    pulse_a_int_clr();
    check("t4_flush_int", a_int, 0);
    check("t4_flush_level", a_level, 0);
    pulse_a_err_clr();

    // 5: start on empty FIFO, words trickle in
    a_start = 1'b1; a_len = 16'd6;
    @(negedge sclk);
    a_start = 1'b0;
    check("t5_busy", a_busy, 1);
    check("t5_wait_tvalid", a_tvalid, 0);
    a_start = 1'b1;
    @(negedge sclk);
    a_start = 1'b0;
    check("t5_start_in_send", a_err, 3'b100);
    pulse_a_err_clr();
    check("t5_wait_tvalid2", a_tvalid, 0);
    push_a(32'hCAFEF00D);
    check("t5_b0_tvalid", a_tvalid, 1);
    check("t5_b0_tdata", a_tdata, 32'hCAFEF00D);
    check("t5_b0_tkeep", a_tkeep, 4'hF);
    check("t5_b0_tlast", a_tlast, 0);
    @(negedge sclk);
    check("t5_gap_tvalid", a_tvalid, 0);
    push_a(32'h0000BEEF);
    check("t5_b1_tvalid", a_tvalid, 1);
    check("t5_b1_tkeep", a_tkeep, 4'h3);
    check("t5_b1_tlast", a_tlast, 1);
    @(negedge sclk);
    check("t5_done_busy", a_busy, 0);
    check("t5_done_err", a_err, 0);
    check("t5_done_int", a_int, 1);
    pulse_a_int_clr();

    // 2: 64-bit, len=16, tready toggling
    b_rx_tuser = 64'hAAAA_BBBB_CCCC_DDDD;
    push_b(t2[0].data);
    push_b(t2[1].data);
    b_start = 1'b1; b_len = 16'd16; b_tready = 1'b0;
    @(negedge sclk);
    b_start = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      check($sformatf("t2_tvalid_c%0d", c), b_tvalid, 1);
      check($sformatf("t2_tdata_c%0d", c), b_tdata, t2[idx].data);
      check($sformatf("t2_tkeep_c%0d", c), b_tkeep, t2[idx].keep);
      check($sformatf("t2_tlast_c%0d", c), b_tlast, t2[idx].last);
      b_tready = (c % 2 == 1);
      @(negedge sclk);
      if (b_tready && b_tvalid === 1'b0) idx = idx;
      if (b_tready) idx++;
    end
    b_tready = 1'b0;
    check("t2_beats", idx, 2);
    check("t2_done_busy", b_busy, 0);
    check("t2_done_tvalid", b_tvalid, 0);
    check("t2_err", b_err, 0);
    check("t2_int", b_int, 0);
    check("t2_tuser", b_tuser, {16'd16, 16'd0, 16'hDDDD, 16'hCCCC});

    // 6: reset mid-frame, then a clean frame
    push_a(32'h1);
    push_a(32'h2);
    push_a(32'h3);
    a_start = 1'b1; a_len = 16'd12; a_tready = 1'b1;
    @(negedge sclk);
    a_start = 1'b0;
    check("t6_pre_tvalid", a_tvalid, 1);
    @(negedge sclk);
    reset = 1'b1;
    #1;
    check("t6_rst_tvalid", a_tvalid, 0);
    check("t6_rst_tlast", a_tlast, 0);
    check("t6_rst_tdata", a_tdata, 0);
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_level", a_level, 0);
    check("t6_rst_tuser", a_tuser, 0);
    @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    push_a(32'h11223344);
    push_a(32'h00000055);
    a_start = 1'b1; a_len = 16'd5;
    @(negedge sclk);
    a_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_tvalid%0d", i), a_tvalid, 1);
      check($sformatf("t6_tdata%0d", i), a_tdata, t6[i].data);
      check($sformatf("t6_tkeep%0d", i), a_tkeep, t6[i].keep);
      check($sformatf("t6_tlast%0d", i), a_tlast, t6[i].last);
      @(negedge sclk);
    end
    check("t6_done_busy", a_busy, 0);
    check("t6_done_err", a_err, 0);
    check("t6_done_level", a_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
